// File: rtl/psram_readback_controller_pkg.sv
// psram_readback_pkg: shared FSM encoding and byte-order constants for the PSRAM readback path
package psram_readback_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_CALIB, ISSUE, WAIT_DATA, DRAIN, DONE} state_t;
  localparam int BYTE_W = 8;
  localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/psram_readback_controller_fifo.sv
// readback_fifo: synchronous first-word-fall-through FIFO with full/empty/level
module readback_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign level = wp - rp;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/psram_readback_controller.sv
// psram_readback_controller: issues PSRAM burst reads and streams the words out as bytes
module psram_readback_controller
  import psram_readback_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 21,
  parameter int BURST_WORDS = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  input  logic              init_calib,
  output logic              cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int NB = DATA_W / BYTE_W;
  state_t state, nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0] count;
  logic [16:0] req, wr;
  logic [7:0] beat, bidx;
  logic [DATA_W-1:0] sh, fifo_q;
  logic [LW-1:0] level;
  logic sv, push, pop, full, empty, last_beat, accept;
  assign accept = sv && out_ready;
  assign pop = !empty && (!sv || (accept && bidx == 8'(NB-1)));
  assign last_beat = state == WAIT_DATA && rd_data_valid && beat == 8'(BURST_WORDS-1);
  // beats past word_count in the final burst are dropped here
  assign push = state == WAIT_DATA && rd_data_valid && wr < {1'b0, count} && !full;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign cmd = 1'b0;
  assign addr = cur_addr;
  assign out_valid = sv;
  assign out_data = LSB_FIRST ? sh[BYTE_W-1:0] : sh[DATA_W-1 -: BYTE_W];
  readback_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(sys_clk), .rst(sys_rst), .push(push), .din(rd_data), .pop(pop),
    .dout(fifo_q), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge sys_clk)
    state <= sys_rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    cmd_en = 1'b0;
    case (state)
      IDLE:       if (start) nxt = word_count == 16'd0 ? DONE : WAIT_CALIB;
      WAIT_CALIB: if (init_calib) nxt = ISSUE;
      ISSUE: if (int'(level) <= FIFO_DEPTH - BURST_WORDS) begin
        cmd_en = 1'b1;
        nxt = WAIT_DATA;
      end
      WAIT_DATA:  if (last_beat) nxt = req < {1'b0, count} ? ISSUE : DRAIN;
      DRAIN:      if (empty && !sv) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur_addr <= '0;
      count <= '0;
      req <= '0;
      wr <= '0;
      beat <= '0;
      bidx <= '0;
      sh <= '0;
      sv <= 1'b0;
    end else begin
      if (state == IDLE && start && word_count != 16'd0) begin
        cur_addr <= start_addr;
        count <= word_count;
        req <= '0;
        wr <= '0;
        beat <= '0;
      end
      if (cmd_en) req <= req + 17'(BURST_WORDS);
      if (push) wr <= wr + 17'd1;
      if (state == WAIT_DATA && rd_data_valid) beat <= last_beat ? 8'd0 : beat + 8'd1;
      if (last_beat) cur_addr <= cur_addr + ADDR_W'(BURST_WORDS * DATA_W / 16);
      if (pop) begin
        sh <= fifo_q;
        bidx <= '0;
        sv <= 1'b1;
      end else if (accept) begin
        sv <= bidx != 8'(NB-1);
        bidx <= bidx + 8'd1;
        sh <= LSB_FIRST ? sh >> BYTE_W : sh << BYTE_W;
      end
    end
  end
endmodule

// File: doc/psram_readback_controller.md
PSRAM_READBACK_CONTROLLER -- requirements
Module: psram_readback_controller

Interface
REQ-001 Parameter DATA_W, 64, width of one PSRAM user-side data word.
REQ-002 Parameter ADDR_W, 21, PSRAM user-side address width (16-bit-halfword units).
REQ-003 Parameter BURST_WORDS, 4, user words returned per read command.
REQ-004 Parameter FIFO_DEPTH, 16, readback FIFO depth in words (power of two, >= 2*BURST_WORDS).
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse launching a readback.
REQ-008 start_addr  in  ADDR_W  first PSRAM address, sampled on start.
REQ-009 word_count  in  16  number of DATA_W words to read, sampled on start.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  one-cycle pulse after the last byte is accepted downstream.
REQ-012 init_calib  in  1  PSRAM IP calibration complete.
REQ-013 cmd  out  1  PSRAM command, 0 = read (constant 0).
REQ-014 cmd_en  out  1  one-cycle command strobe.
REQ-015 addr  out  ADDR_W  command address, valid with cmd_en.
REQ-016 rd_data  in  DATA_W  read data word from the PSRAM IP.
REQ-017 rd_data_valid  in  1  qualifies rd_data; BURST_WORDS consecutive cycles per command.
REQ-018 out_data  out  8  byte stream to downstream (UART/host link).
REQ-019 out_valid  out  1  out_data valid.
REQ-020 out_ready  in  1  downstream accepts when out_valid && out_ready.

Function
REQ-021 States IDLE, WAIT_CALIB, ISSUE, WAIT_DATA, DRAIN, DONE.
REQ-022 IDLE: start with word_count != 0 -> WAIT_CALIB, latch addr/count, busy=1; start with word_count == 0 -> DONE directly.
REQ-023 start while busy is ignored; latched parameters unchanged.
REQ-024 WAIT_CALIB -> ISSUE when init_calib=1; otherwise hold.
REQ-025 ISSUE: cmd_en=1 for exactly one cycle only when FIFO free space >= BURST_WORDS; then -> WAIT_DATA.
REQ-026 WAIT_DATA: count rd_data_valid beats; after BURST_WORDS beats, next address = addr + BURST_WORDS*DATA_W/16; -> ISSUE if words requested < word_count, else DRAIN.
REQ-027 Only the first word_count words overall are written to the FIFO; excess beats of a final partial burst are discarded.
REQ-028 rd_data_valid outside WAIT_DATA is ignored; the FIFO is never overflowed (guaranteed by REQ-025).
REQ-029 Serializer pops one word and emits DATA_W/8 bytes, byte 0 = word[7:0] first, little-endian.
REQ-030 out_data/out_valid hold stable while out_valid && !out_ready; no byte dropped or duplicated.
REQ-031 Serializer runs concurrently with ISSUE/WAIT_DATA; pop and push in the same cycle are both honoured.
REQ-032 DRAIN -> DONE when FIFO empty and last byte accepted; DONE asserts done one cycle, busy=0, -> IDLE.
REQ-033 addr wraps modulo 2^ADDR_W without error.
REQ-034 Latency: cmd_en no earlier than the cycle after start and not before init_calib=1.

Reset
REQ-035 sys_rst=1 returns state to IDLE, clears FIFO, counters and serializer, mid-operation included; in-flight rd_data_valid beats are dropped.
REQ-036 Reset values: busy=0, done=0, cmd_en=0, cmd=0, addr=0, out_valid=0, out_data=0.

Structure
REQ-037 State encoding and byte-order constants reside in shared package psram_readback_pkg.
REQ-038 The FIFO is a separate sub-module readback_fifo (synchronous, first-word-fall-through, full/empty/level outputs).

Verification
REQ-039 start_addr=0x100, word_count=8, out_ready=1, model returns incrementing words -> 2 commands at 0x100, 0x110; 64 bytes in order; one done pulse.
REQ-040 word_count=5 -> 2 commands; exactly 40 bytes out; 3 trailing beats discarded.
REQ-041 word_count=0 -> no cmd_en; done one cycle after start.
REQ-042 init_calib=0 for 100 cycles after start -> no cmd_en until it rises.
REQ-043 out_ready low for 200 cycles, word_count=32 -> commands stall at FIFO full, no overflow, all 256 bytes correct.
REQ-044 sys_rst asserted during WAIT_DATA -> all outputs at reset values next cycle; new start works normally.
